divider_scheduler: RTL and testbench

- Round-robin scheduler that shares one divider instance among NUM_CH gain-control channels.
- Each channel posts a (reference, error) pair. The block grants one channel, drives the divider's operand/valid inputs for exactly one cycle, waits the divider's fixed result latency, then captures the quotient/fractional result.
- The result is returned to the granted channel with a one-cycle done strobe.
- Sits between the per-channel AGC loops and the shared divider wrapper.

---
 rtl/divider_scheduler.sv | 165 ++++++++++++++++
 tb/tb_divider_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_scheduler.sv
// Round-robin arbiter sharing one fixed-latency divider among NUM_CH channels.
// One operation in flight; the result returns to the granted channel with a done strobe.
module divider_scheduler #(
    parameter int NUM_CH              = 4,
    parameter int AMPLITUDE_DATA_SIZE = 16,
    parameter int QUOTIENT_SIZE       = 8,
    parameter int FRACTIONAL_SIZE     = 8,
    parameter int DIV_LATENCY         = 2
) (
    input  logic                                  i_clock,
    input  logic                                  i_reset,
    input  logic [NUM_CH-1:0]                     i_req,
    input  logic [NUM_CH*AMPLITUDE_DATA_SIZE-1:0] i_reference,
    input  logic [NUM_CH*AMPLITUDE_DATA_SIZE-1:0] i_error,
    output logic [AMPLITUDE_DATA_SIZE-1:0]        o_div_reference,
    output logic [AMPLITUDE_DATA_SIZE-1:0]        o_div_error,
    output logic                                  o_div_valid,
    input  logic [QUOTIENT_SIZE-1:0]              i_div_quotient,
    input  logic [FRACTIONAL_SIZE-1:0]            i_div_fractional,
    output logic [NUM_CH-1:0]                     o_grant,
    output logic [NUM_CH-1:0]                     o_done,
    output logic [QUOTIENT_SIZE-1:0]              o_quotient,
    output logic [FRACTIONAL_SIZE-1:0]            o_fractional,
    output logic                                  o_div_by_zero,
    output logic                                  o_busy
);

    localparam int W  = AMPLITUDE_DATA_SIZE;
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(DIV_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          gidx;
    logic [NUM_CH-1:0]      grant;
    logic [W-1:0]           op_ref;
    logic [W-1:0]           op_err;
    logic [CW-1:0]          cnt;
    logic [QUOTIENT_SIZE-1:0]   quot;
    logic [FRACTIONAL_SIZE-1:0] frac;
    logic                   dbz;

    logic                   sel_found;
    logic [IW-1:0]          sel_idx;
    logic [W-1:0]           sel_ref;
    logic [W-1:0]           sel_err;

    // First requester at or after the pointer, wrapping modulo NUM_CH.
    always_comb begin : select
        int k;
        k         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_CH) begin
                k = k - NUM_CH;
            end
            if (!sel_found && i_req[k[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = k[IW-1:0];
            end
        end
    end

    assign sel_ref = i_reference[int'(sel_idx)*W +: W];
    assign sel_err = i_error[int'(sel_idx)*W +: W];

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_next = (sel_ref == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            ptr    <= '0;
            gidx   <= '0;
            grant  <= '0;
            op_ref <= '0;
            op_err <= '0;
            cnt    <= '0;
            quot   <= '0;
            frac   <= '0;
            dbz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        gidx   <= sel_idx;
                        grant  <= NUM_CH'(1) << sel_idx;
                        op_ref <= sel_ref;
                        op_err <= sel_err;
                        // Zero divisor skips the divider and reports saturated ones.
                        if (sel_ref == '0) begin
                            dbz  <= 1'b1;
                            quot <= '1;
                            frac <= '1;
                        end else begin
                            dbz <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= CW'(DIV_LATENCY);
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        quot <= i_div_quotient;
                        frac <= i_div_fractional;
                    end
                end
                DONE: begin
                    grant <= '0;
                    dbz   <= 1'b0;
                    ptr   <= (gidx == IW'(NUM_CH - 1)) ? '0 : gidx + IW'(1);
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    assign o_div_reference = op_ref;
    assign o_div_error     = op_err;
    assign o_div_valid     = (state == ISSUE);
    assign o_grant         = grant;
    assign o_done          = (state == DONE) ? grant : '0;
    assign o_quotient      = quot;
    assign o_fractional    = frac;
    assign o_div_by_zero   = (state == DONE) && dbz;
    assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_divider_scheduler.sv
// Directed plus randomized bench for divider_scheduler with a 2-stage divider model
// that drives junk on its outputs except in the single valid-result cycle.
module tb_divider_scheduler;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int QS  = 8;
    localparam int FS  = 8;
    localparam int LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   ref_bus;
    logic [N*W-1:0]   err_bus;
    logic [W-1:0]     div_ref;
    logic [W-1:0]     div_err;
    logic             div_valid;
    logic [QS-1:0]    div_q;
    logic [FS-1:0]    div_f;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [QS-1:0]    quot;
    logic [FS-1:0]    frac;
    logic             dbz;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int mptr;
    int exp_valid;
    int vcnt = 0;
    logic [7:0] last_q;
    logic [7:0] last_f;

    always #5 clk = ~clk;

    divider_scheduler #(
        .NUM_CH(N),
        .AMPLITUDE_DATA_SIZE(W),
        .QUOTIENT_SIZE(QS),
        .FRACTIONAL_SIZE(FS),
        .DIV_LATENCY(LAT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .i_req(req),
        .i_reference(ref_bus),
        .i_error(err_bus),
        .o_div_reference(div_ref),
        .o_div_error(div_err),
        .o_div_valid(div_valid),
        .i_div_quotient(div_q),
        .i_div_fractional(div_f),
        .o_grant(grant),
        .o_done(done),
        .o_quotient(quot),
        .o_fractional(frac),
        .o_div_by_zero(dbz),
        .o_busy(busy)
    );

    // 8.8 fixed-point error/reference, saturated to 16 bits.
    function automatic logic [15:0] divide(input logic [15:0] e, input logic [15:0] r);
        logic [23:0] v;
        v = {e, 8'h00} / {8'h00, r};
        return (v > 24'h00FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    function automatic int pick(input logic [N-1:0] rq, input int p);
        for (int i = 0; i < N; i++) begin
            if (rq[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    logic        s1v = 1'b0;
    logic        s2v = 1'b0;
    logic [15:0] s1 = '0;
    logic [15:0] s2 = '0;
    logic [15:0] junk = '0;

    always @(posedge clk) begin
        junk <= 16'($urandom);
        s1v  <= div_valid;
        s2v  <= s1v;
        s1   <= (div_ref != 0) ? divide(div_err, div_ref) : 16'hDEAD;
        s2   <= s1;
        if (div_valid) vcnt <= vcnt + 1;
    end

    assign div_q = s2v ? s2[15:8] : junk[7:0];
    assign div_f = s2v ? s2[7:0]  : junk[15:8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [15:0] r, input logic [15:0] e);
        ref_bus[c*W +: W] = r;
        err_bus[c*W +: W] = e;
    endtask

    task automatic randomize_inputs();
        for (int c = 0; c < N; c++) begin
            set_ch(c, ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom),
                   16'($urandom));
        end
        req = 4'($urandom_range(1, 15));
    endtask

    // Called in an IDLE cycle whose inputs are already driven; returns in the done cycle.
    task automatic serve(input logic [N-1:0] blip, input logic [15:0] new_err);
        int c;
        logic [N-1:0] oh;
        logic [N-1:0] req0;
        logic [15:0] r;
        logic [15:0] e;
        logic [15:0] q;
        req0 = req;
        chk("idle_busy", busy, 0);
        chk("idle_grant", grant, 0);
        chk("idle_done", done, 0);
        chk("idle_dbz", dbz, 0);
        chk("hold_result", {quot, frac}, {last_q, last_f});
        c = pick(req0, mptr);
        if (c < 0) return;
        oh = N'(1) << c;
        r = ref_bus[c*W +: W];
        e = err_bus[c*W +: W];
        step();
        chk("grant", grant, oh);
        chk("busy", busy, 1);
        if (r == 0) begin
            chk("zd_done", done, oh);
            chk("zd_flag", dbz, 1);
            chk("zd_valid", div_valid, 0);
            chk("zd_result", {quot, frac}, 16'hFFFF);
            last_q = 8'hFF;
            last_f = 8'hFF;
            mptr = (c + 1) % N;
            return;
        end
        chk("issue_valid", div_valid, 1);
        chk("issue_done", done, 0);
        chk("issue_ref", div_ref, r);
        chk("issue_err", div_err, e);
        exp_valid++;
        req = req0 | blip;
        step();
        req = req0;
        err_bus[c*W +: W] = new_err;
        chk("wait_valid", div_valid, 0);
        chk("wait_done", done, 0);
        step();
        chk("wait_err_stable", div_err, e);
        chk("wait_ref_stable", div_ref, r);
        chk("wait2_done", done, 0);
        chk("wait2_valid", div_valid, 0);
        step();
        q = divide(e, r);
        chk("done", done, oh);
        chk("done_dbz", dbz, 0);
        chk("done_valid", div_valid, 0);
        chk("result", {quot, frac}, q);
        chk("valid_count", vcnt, exp_valid);
        last_q = q[15:8];
        last_f = q[7:0];
        mptr = (c + 1) % N;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        ref_bus = '0;
        err_bus = '0;
        mptr = 0;
        exp_valid = 0;
        last_q = 8'h00;
        last_f = 8'h00;
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", div_valid, 0);
        chk("rst_div_ref", div_ref, 0);
        chk("rst_div_err", div_err, 0);
        chk("rst_q", quot, 0);
        chk("rst_f", frac, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        step();

        // Single request on ch1: 0x0100 / 0x0200 = 0.5
        set_ch(1, 16'h0200, 16'h0100);
        req = 4'b0010;
        serve('0, 16'h0100);
        chk("t1_q", quot, 8'h00);
        chk("t1_f", frac, 8'h80);
        req = '0;
        step();

        // Round-robin with all channels held from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        mptr = 0;
        last_q = 8'h00;
        last_f = 8'h00;
        for (int c = 0; c < N; c++) begin
            set_ch(c, 16'($urandom_range(1, 16'hFFFF)), 16'($urandom));
        end
        req = 4'b1111;
        serve('0, 16'($urandom));
        for (int t = 0; t < 4; t++) begin
            chk("rr_order", grant, N'(1) << t);
            set_ch(t, 16'($urandom_range(1, 16'hFFFF)), 16'($urandom));
            step();
            serve('0, 16'($urandom));
        end
        chk("rr_wrap", done, 4'b0001);
        req = '0;
        step();

        // Zero divide on ch2
        set_ch(2, 16'h0000, 16'h1234);
        req = 4'b0100;
        serve('0, 16'h0);
        chk("t3_no_valid", vcnt, exp_valid);
        req = '0;
        step();

        // Operand stability: error changes to 0x0001 during WAIT
        set_ch(0, 16'h0100, 16'h0300);
        req = 4'b0001;
        serve('0, 16'h0001);
        chk("t4_q", quot, 8'h03);
        chk("t4_f", frac, 8'h00);
        req = '0;
        step();

        // Reset in WAIT aborts; service then restarts from pointer 0
        set_ch(2, 16'h0040, 16'h1000);
        req = 4'b0100;
        step();
        chk("t5_grant", grant, 4'b0100);
        exp_valid++;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("t5_grant0", grant, 0);
        chk("t5_done0", done, 0);
        chk("t5_valid0", div_valid, 0);
        chk("t5_ref0", div_ref, 0);
        chk("t5_err0", div_err, 0);
        chk("t5_q0", {quot, frac}, 0);
        chk("t5_dbz0", dbz, 0);
        chk("t5_busy0", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_done", done, 0);
        end
        rst = 1'b0;
        mptr = 0;
        last_q = 8'h00;
        last_f = 8'h00;
        set_ch(1, 16'($urandom_range(1, 16'hFFFF)), 16'($urandom));
        req = 4'b0110;
        serve('0, 16'($urandom));
        req = '0;
        step();

        // ch3 blips while ch0 is served and is never granted
        set_ch(0, 16'($urandom_range(1, 16'hFFFF)), 16'($urandom));
        set_ch(3, 16'h0010, 16'h0100);
        req = 4'b0001;
        serve(4'b1000, 16'($urandom));
        req = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_busy", busy, 0);
            chk("t6_grant", grant, 0);
            chk("t6_done", done, 0);
        end

        // Randomized traffic against the reference model
        randomize_inputs();
        serve(4'($urandom), 16'($urandom));
        for (int t = 0; t < 40; t++) begin
            randomize_inputs();
            step();
            serve(4'($urandom), 16'($urandom));
        end
        chk("final_valid_count", vcnt, exp_valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
